svc_rv_mem_arbiter: RTL and testbench
=====================================

// Module: svc_rv_mem_arbiter
//
// PURPOSE
// - Shares one backing memory port between the svc_rv imem (read) and dmem
//   (read/write) ports, so a core can run from a unified memory.
// - Drives imem_stall/dmem_stall back to the core, with BRAM-style
//   (MEM_TYPE=1) timing: rdata is due the cycle after the request; stall is
//   raised while it is late.
// - Sits between svc_rv and a single-port SRAM, cache or bus bridge.
//
// PARAMETERS
// - AW          32  address width (byte address)
// - DW          32  data width
// - D_BURST_MAX  4  max consecutive dmem grants while imem waits
//                   (1..15; 0 is illegal)
//
// PORTS
// - clk            in   1      clock
// - rst_n          in   1      synchronous active-low reset
// - imem_ren       in   1      core instruction read request (ignored while imem_stall)
// - imem_raddr     in   AW     instruction address
// - imem_rdata     out  DW     instruction data
// - imem_stall     out  1      imem response late; core holds
// - dmem_ren       in   1      core data read request (ignored while dmem_stall)
// - dmem_raddr     in   AW     data read address
// - dmem_rdata     out  DW     data read result
// - dmem_we        in   1      core data write request (ignored while dmem_stall)
// - dmem_waddr     in   AW     write address
// - dmem_wdata     in   DW     write data
// - dmem_wstrb     in   DW/8   write byte strobes
// - dmem_stall     out  1      dmem response/ack late; core holds
// - mem_req_valid  out  1      backing request valid
// - mem_req_ready  in   1      backing request accepted (valid && ready)
// - mem_req_we     out  1      1 = write
// - mem_req_addr   out  AW     request address
// - mem_req_wdata  out  DW     write data
// - mem_req_wstrb  out  DW/8   write strobes
// - mem_resp_valid in   1      response/write-ack; in order, >=1 cycle after accept
// - mem_resp_rdata in   DW     read data (don't-care for write acks)
//
// BEHAVIOUR
// - Reset values: stalls 0; mem_req_valid 0; imem_rdata 32'h00000013 (NOP);
//   dmem_rdata 0; FSM IDLE; pending latches clear; burst counter 0.
// - Request capture: a core request (ren or we) is taken when the port is
//   not busy. It is issued combinationally the same cycle if granted,
//   otherwise it is latched (addr/we/wdata/wstrb) as pending. The port is
//   busy from the next cycle until its response.
// - dmem_ren and dmem_we together in one cycle is illegal (core never does it).
// - At most one outstanding backing transaction.
// - FSM states:
//   - IDLE: nothing outstanding.
//   - WAIT: one outstanding; owner register records I or D.
// - Issue is allowed in IDLE, or in WAIT on the cycle mem_resp_valid
//   arrives (back-to-back).
// - Transitions:
//   - Accept (valid && ready) -> WAIT.
//   - Response with no new accept -> IDLE.
//   - Response with a new accept -> stay in WAIT with the new owner.
// - mem_req_* are held stable while valid && !ready; no re-arbitration once
//   valid is asserted.
// - Arbitration (live request or pending latch, per port):
//   - dmem wins, unless imem is requesting and the burst counter equals
//     D_BURST_MAX; then imem wins.
//   - Counter increments on each dmem accept while imem is requesting.
//   - Counter clears on an imem accept, or when imem is not requesting.
// - Stall: port_stall = port_busy && !(mem_resp_valid && owner == port).
//   - Zero-wait case: request at T, accept at T, resp at T+1 -> no stall.
// - rdata: equals mem_resp_rdata in the owner's response cycle (pass-through);
//   otherwise the registered copy of the last read response. Held stable until
//   the next read response for that port. Write acks do not update dmem_rdata.
// - Simultaneous imem+dmem requests: dmem is issued, imem is latched pending;
//   imem_stall is high until imem's own response.
// - Reset mid-operation: all state cleared. The backing memory shares rst_n and
//   drops in-flight transactions. A mem_resp_valid while IDLE is ignored.
//
// STRUCTURE
// - svc_rv_mem_arb_pkg:
//   - typedef owner_t {OWN_I, OWN_D}
//   - typedef state_t {IDLE, WAIT}
//   - struct mem_req_t {we, addr, wdata, wstrb}
//   - localparam NOP_INSN = 32'h00000013
// - Sub-module svc_rv_mem_arb_port: per-port pending latch, busy flag and
//   rdata hold register. Instantiated twice (imem with we tied 0).
//
// TESTING
// - Single imem read at 0x40, ready=1, resp at T+1 = 0xDEADBEEF
//   -> imem_stall never high; imem_rdata = 0xDEADBEEF at T+1.
// - imem 0x10 and dmem read 0x80 in the same cycle, resp latency 1
//   -> dmem issued first; imem issued at resp cycle T+1;
//      imem_stall high T+1, low T+2.
// - dmem write 0x100, wdata 0xA5A5A5A5, wstrb 4'b0011, ready low 3 cycles
//   -> mem_req_* stable 3 cycles; dmem_stall high until the ack;
//      dmem_rdata unchanged.
// - Continuous dmem reads with imem waiting, D_BURST_MAX=4
//   -> exactly 4 dmem accepts, then 1 imem accept; pattern repeats.
// - Resp latency 3, rst_n low in the 2nd wait cycle
//   -> next cycle: stalls 0, mem_req_valid 0, imem_rdata 0x00000013;
//      a stray mem_resp_valid is ignored.
// - Read resp 0x1234 to dmem, then 5 idle cycles
//   -> dmem_rdata holds 0x1234 throughout.

Source files
------------

// File: rtl/svc_rv_mem_arb_pkg.sv
// svc_rv_mem_arb_pkg: shared types and constants for the svc_rv memory arbiter
package svc_rv_mem_arb_pkg;
  typedef enum logic {OWN_I, OWN_D} owner_t;
  typedef enum logic {IDLE, WAIT} state_t;
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;
  localparam logic [31:0] NOP_INSN = 32'h00000013;
endpackage

// File: rtl/svc_rv_mem_arb_port.sv
// svc_rv_mem_arb_port: per-port pending latch, busy tracking and rdata hold
module svc_rv_mem_arb_port
  import svc_rv_mem_arb_pkg::*;
#(
  parameter int             AW       = 32,
  parameter int             DW       = 32,
  parameter logic [DW-1:0]  RST_DATA = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req,
  input  logic            we,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] wstrb,
  input  logic            accept,
  input  logic            resp,
  input  logic [DW-1:0]   resp_rdata,
  output logic            want,
  output logic            out_we,
  output logic [AW-1:0]   out_addr,
  output logic [DW-1:0]   out_wdata,
  output logic [DW/8-1:0] out_wstrb,
  output logic            stall,
  output logic [DW-1:0]   rdata
);
  logic            pend, busy, out_rd, take;
  logic            pend_we;
  logic [AW-1:0]   pend_addr;
  logic [DW-1:0]   pend_wdata, rdata_q;
  logic [DW/8-1:0] pend_wstrb;

  // the port frees up in its own response cycle, so a new request can ride along
  always_comb begin
    stall     = busy && !resp;
    take      = req && !stall;
    want      = pend || take;
    out_we    = pend ? pend_we : we;
    out_addr  = pend ? pend_addr : addr;
    out_wdata = pend ? pend_wdata : wdata;
    out_wstrb = pend ? pend_wstrb : wstrb;
    rdata     = (resp && out_rd) ? resp_rdata : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend       <= 1'b0;
      busy       <= 1'b0;
      out_rd     <= 1'b0;
      pend_we    <= 1'b0;
      pend_addr  <= '0;
      pend_wdata <= '0;
      pend_wstrb <= '0;
      rdata_q    <= RST_DATA;
    end else begin
      pend <= (pend || take) && !accept;
      busy <= take || (busy && !resp);
      if (take) begin
        pend_we    <= we;
        pend_addr  <= addr;
        pend_wdata <= wdata;
        pend_wstrb <= wstrb;
      end
      if (accept) out_rd <= !out_we;
      if (resp && out_rd) rdata_q <= resp_rdata;
    end
  end
endmodule

// File: rtl/svc_rv_mem_arbiter.sv
// svc_rv_mem_arbiter: shares one backing memory port between svc_rv imem and dmem
module svc_rv_mem_arbiter
  import svc_rv_mem_arb_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int D_BURST_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            imem_ren,
  input  logic [AW-1:0]   imem_raddr,
  output logic [DW-1:0]   imem_rdata,
  output logic            imem_stall,
  input  logic            dmem_ren,
  input  logic [AW-1:0]   dmem_raddr,
  output logic [DW-1:0]   dmem_rdata,
  input  logic            dmem_we,
  input  logic [AW-1:0]   dmem_waddr,
  input  logic [DW-1:0]   dmem_wdata,
  input  logic [DW/8-1:0] dmem_wstrb,
  output logic            dmem_stall,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_req_we,
  output logic [AW-1:0]   mem_req_addr,
  output logic [DW-1:0]   mem_req_wdata,
  output logic [DW/8-1:0] mem_req_wstrb,
  input  logic            mem_resp_valid,
  input  logic [DW-1:0]   mem_resp_rdata
);
  state_t          state;
  owner_t          owner, lock_own, gnt;
  logic            lock, resp_i, resp_d, acc;
  logic [3:0]      cnt;
  logic            i_want, i_we, d_want, d_we;
  logic [AW-1:0]   i_addr, d_addr;
  logic [DW-1:0]   i_wdata, d_wdata;
  logic [DW/8-1:0] i_wstrb, d_wstrb;

  // a stalled request keeps its grant until accepted
  always_comb begin
    resp_i        = mem_resp_valid && state == WAIT && owner == OWN_I;
    resp_d        = mem_resp_valid && state == WAIT && owner == OWN_D;
    gnt           = lock ? lock_own : (i_want && (!d_want || cnt == 4'(D_BURST_MAX))) ? OWN_I : OWN_D;
    mem_req_valid = rst_n && (state == IDLE || mem_resp_valid) && (i_want || d_want);
    acc           = mem_req_valid && mem_req_ready;
    mem_req_we    = gnt == OWN_I ? i_we : d_we;
    mem_req_addr  = gnt == OWN_I ? i_addr : d_addr;
    mem_req_wdata = gnt == OWN_I ? i_wdata : d_wdata;
    mem_req_wstrb = gnt == OWN_I ? i_wstrb : d_wstrb;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= OWN_I;
      lock     <= 1'b0;
      lock_own <= OWN_I;
      cnt      <= '0;
    end else begin
      state    <= acc ? WAIT : mem_resp_valid ? IDLE : state;
      if (acc) owner <= gnt;
      lock     <= mem_req_valid && !mem_req_ready;
      lock_own <= gnt;
      cnt      <= (!i_want || (acc && gnt == OWN_I)) ? '0 : acc ? cnt + 4'd1 : cnt;
    end
  end

  svc_rv_mem_arb_port #(.AW(AW), .DW(DW), .RST_DATA(DW'(NOP_INSN))) u_imem (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (imem_ren),
    .we         (1'b0),
    .addr       (imem_raddr),
    .wdata      ('0),
    .wstrb      ('0),
    .accept     (acc && gnt == OWN_I),
    .resp       (resp_i),
    .resp_rdata (mem_resp_rdata),
    .want       (i_want),
    .out_we     (i_we),
    .out_addr   (i_addr),
    .out_wdata  (i_wdata),
    .out_wstrb  (i_wstrb),
    .stall      (imem_stall),
    .rdata      (imem_rdata)
  );

  svc_rv_mem_arb_port #(.AW(AW), .DW(DW), .RST_DATA('0)) u_dmem (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (dmem_ren || dmem_we),
    .we         (dmem_we),
    .addr       (dmem_we ? dmem_waddr : dmem_raddr),
    .wdata      (dmem_wdata),
    .wstrb      (dmem_wstrb),
    .accept     (acc && gnt == OWN_D),
    .resp       (resp_d),
    .resp_rdata (mem_resp_rdata),
    .want       (d_want),
    .out_we     (d_we),
    .out_addr   (d_addr),
    .out_wdata  (d_wdata),
    .out_wstrb  (d_wstrb),
    .stall      (dmem_stall),
    .rdata      (dmem_rdata)
  );
endmodule

// File: tb/tb_svc_rv_mem_arbiter.sv
// tb_svc_rv_mem_arbiter: directed self-checking bench for svc_rv_mem_arbiter
module tb_svc_rv_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_ren = 1'b0;
  logic [31:0] imem_raddr = '0;
  logic [31:0] imem_rdata;
  logic        imem_stall;
  logic        dmem_ren = 1'b0;
  logic [31:0] dmem_raddr = '0;
  logic [31:0] dmem_rdata;
  logic        dmem_we = 1'b0;
  logic [31:0] dmem_waddr = '0;
  logic [31:0] dmem_wdata = '0;
  logic [3:0]  dmem_wstrb = '0;
  logic        dmem_stall;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_rdata = '0;

  int          tests = 0;
  int          fails = 0;
  int          lat = 1;
  int          mdl_cnt = 0;
  logic [31:0] mdl_data = '0;
  bit          acc_log[$];

  always #5 clk = ~clk;

  svc_rv_mem_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_ren       (imem_ren),
    .imem_raddr     (imem_raddr),
    .imem_rdata     (imem_rdata),
    .imem_stall     (imem_stall),
    .dmem_ren       (dmem_ren),
    .dmem_raddr     (dmem_raddr),
    .dmem_rdata     (dmem_rdata),
    .dmem_we        (dmem_we),
    .dmem_waddr     (dmem_waddr),
    .dmem_wdata     (dmem_wdata),
    .dmem_wstrb     (dmem_wstrb),
    .dmem_stall     (dmem_stall),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_we     (mem_req_we),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wstrb  (mem_req_wstrb),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata)
  );

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return a == 32'h40 ? 32'hDEADBEEF : a == 32'h200 ? 32'h00001234 : (32'hC0DE0000 | a);
  endfunction

  task automatic settle();
    @(negedge clk);
  endtask

  // backing memory: samples the accept mid-cycle, answers lat cycles later
  task automatic adv();
    logic acc, we_s;
    logic [31:0] a;
    acc  = mem_req_valid && mem_req_ready;
    we_s = mem_req_we;
    a    = mem_req_addr;
    @(posedge clk);
    #1;
    mem_resp_valid = 1'b0;
    if (!rst_n) mdl_cnt = 0;
    else begin
      if (mdl_cnt > 0) begin
        mdl_cnt--;
        if (mdl_cnt == 0) begin mem_resp_valid = 1'b1; mem_resp_rdata = mdl_data; end
      end
      if (acc) begin
        acc_log.push_back(a == 32'h20);
        mdl_data = we_s ? 32'hBAD0BAD0 : mem_val(a);
        mdl_cnt  = lat - 1;
        if (mdl_cnt == 0) begin mem_resp_valid = 1'b1; mem_resp_rdata = mdl_data; end
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) begin settle(); adv(); end
    settle();
    tests++; if ({imem_stall, dmem_stall, mem_req_valid} !== 3'b000) begin fails++; $display("FAIL reset_ctrl got %b exp 000", {imem_stall, dmem_stall, mem_req_valid}); end
    tests++; if (imem_rdata !== 32'h00000013) begin fails++; $display("FAIL reset_imem_rdata got %h exp 00000013", imem_rdata); end
    tests++; if (dmem_rdata !== 32'h0) begin fails++; $display("FAIL reset_dmem_rdata got %h exp 0", dmem_rdata); end
    adv();
    rst_n = 1'b1;
  endtask

  task automatic test_single_imem();
    imem_ren = 1'b1; imem_raddr = 32'h40;
    settle();
    tests++; if ({mem_req_valid, mem_req_we, mem_req_addr} !== {2'b10, 32'h40}) begin fails++; $display("FAIL single_req got %b%b %h exp 10 00000040", mem_req_valid, mem_req_we, mem_req_addr); end
    tests++; if (imem_stall !== 1'b0) begin fails++; $display("FAIL single_stall_t0 got %b exp 0", imem_stall); end
    adv();
    imem_ren = 1'b0;
    settle();
    tests++; if (imem_stall !== 1'b0) begin fails++; $display("FAIL single_stall_t1 got %b exp 0", imem_stall); end
    tests++; if (imem_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL single_rdata got %h exp deadbeef", imem_rdata); end
    adv();
    settle();
    tests++; if (imem_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL single_rdata_hold got %h exp deadbeef", imem_rdata); end
    tests++; if (mem_req_valid !== 1'b0) begin fails++; $display("FAIL single_idle_valid got %b exp 0", mem_req_valid); end
    adv();
  endtask

  task automatic test_simultaneous();
    imem_ren = 1'b1; imem_raddr = 32'h10;
    dmem_ren = 1'b1; dmem_raddr = 32'h80;
    settle();
    tests++; if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h80}) begin fails++; $display("FAIL simul_first got %b %h exp 1 00000080", mem_req_valid, mem_req_addr); end
    tests++; if ({imem_stall, dmem_stall} !== 2'b00) begin fails++; $display("FAIL simul_stall_t0 got %b exp 00", {imem_stall, dmem_stall}); end
    adv();
    imem_ren = 1'b0; dmem_ren = 1'b0;
    settle();
    tests++; if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h10}) begin fails++; $display("FAIL simul_second got %b %h exp 1 00000010", mem_req_valid, mem_req_addr); end
    tests++; if ({imem_stall, dmem_stall} !== 2'b10) begin fails++; $display("FAIL simul_stall_t1 got %b exp 10", {imem_stall, dmem_stall}); end
    tests++; if (dmem_rdata !== 32'hC0DE0080) begin fails++; $display("FAIL simul_dmem_rdata got %h exp c0de0080", dmem_rdata); end
    adv();
    settle();
    tests++; if (imem_stall !== 1'b0) begin fails++; $display("FAIL simul_stall_t2 got %b exp 0", imem_stall); end
    tests++; if (imem_rdata !== 32'hC0DE0010) begin fails++; $display("FAIL simul_imem_rdata got %h exp c0de0010", imem_rdata); end
    adv();
  endtask

  task automatic test_write_backpressure();
    logic [69:0] exp_req;
    exp_req = {1'b1, 1'b1, 32'h100, 32'hA5A5A5A5, 4'b0011};
    mem_req_ready = 1'b0;
    dmem_we = 1'b1; dmem_waddr = 32'h100; dmem_wdata = 32'hA5A5A5A5; dmem_wstrb = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      settle();
      tests++; if ({mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb} !== exp_req) begin fails++; $display("FAIL write_hold_%0d got %h exp %h", k, {mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb}, exp_req); end
      tests++; if (dmem_stall !== (k > 0)) begin fails++; $display("FAIL write_stall_%0d got %b exp %b", k, dmem_stall, k > 0); end
      adv();
      if (k == 0) begin dmem_we = 1'b0; dmem_waddr = '0; dmem_wdata = '0; dmem_wstrb = '0; end
      if (k == 2) mem_req_ready = 1'b1;
    end
    settle();
    tests++; if (dmem_stall !== 1'b0) begin fails++; $display("FAIL write_ack_stall got %b exp 0", dmem_stall); end
    tests++; if (dmem_rdata !== 32'hC0DE0080) begin fails++; $display("FAIL write_ack_rdata got %h exp c0de0080", dmem_rdata); end
    adv();
    settle();
    tests++; if (dmem_rdata !== 32'hC0DE0080) begin fails++; $display("FAIL write_after_rdata got %h exp c0de0080", dmem_rdata); end
    adv();
  endtask

  task automatic test_burst_fairness();
    acc_log.delete();
    imem_ren = 1'b1; imem_raddr = 32'h20;
    dmem_ren = 1'b1; dmem_raddr = 32'h84;
    repeat (10) begin settle(); adv(); end
    imem_ren = 1'b0; dmem_ren = 1'b0;
    repeat (5) begin settle(); adv(); end
    tests++; if (acc_log.size() < 10) begin fails++; $display("FAIL burst_count got %0d exp >=10", acc_log.size()); end
    for (int k = 0; k < 10 && k < acc_log.size(); k++) begin
      bit e;
      e = (k % 5 == 4);
      tests++; if (acc_log[k] !== e) begin fails++; $display("FAIL burst_owner_%0d got %b exp %b", k, acc_log[k], e); end
    end
  endtask

  task automatic test_reset_mid();
    lat = 3;
    dmem_ren = 1'b1; dmem_raddr = 32'h84;
    settle(); adv();
    dmem_ren = 1'b0;
    settle();
    tests++; if (dmem_stall !== 1'b1) begin fails++; $display("FAIL midrst_wait_stall got %b exp 1", dmem_stall); end
    adv();
    rst_n = 1'b0;
    settle(); adv();
    rst_n = 1'b1;
    settle();
    tests++; if ({imem_stall, dmem_stall, mem_req_valid} !== 3'b000) begin fails++; $display("FAIL midrst_ctrl got %b exp 000", {imem_stall, dmem_stall, mem_req_valid}); end
    tests++; if (imem_rdata !== 32'h00000013) begin fails++; $display("FAIL midrst_imem_rdata got %h exp 00000013", imem_rdata); end
    tests++; if (dmem_rdata !== 32'h0) begin fails++; $display("FAIL midrst_dmem_rdata got %h exp 0", dmem_rdata); end
    adv();
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hFFFFFFFF;
    settle();
    tests++; if ({dmem_rdata, imem_rdata} !== {32'h0, 32'h00000013}) begin fails++; $display("FAIL stray_rdata got %h %h exp 0 00000013", dmem_rdata, imem_rdata); end
    tests++; if ({imem_stall, dmem_stall, mem_req_valid} !== 3'b000) begin fails++; $display("FAIL stray_ctrl got %b exp 000", {imem_stall, dmem_stall, mem_req_valid}); end
    adv();
    settle();
    tests++; if (dmem_rdata !== 32'h0) begin fails++; $display("FAIL stray_after got %h exp 0", dmem_rdata); end
    adv();
    lat = 1;
  endtask

  task automatic test_rdata_hold();
    dmem_ren = 1'b1; dmem_raddr = 32'h200;
    settle(); adv();
    dmem_ren = 1'b0;
    for (int k = 0; k < 6; k++) begin
      settle();
      tests++; if (dmem_rdata !== 32'h00001234) begin fails++; $display("FAIL hold_%0d got %h exp 00001234", k, dmem_rdata); end
      adv();
    end
  endtask

  initial begin
    test_reset();
    test_single_imem();
    test_simultaneous();
    test_write_backpressure();
    test_burst_fairness();
    test_reset_mid();
    test_rdata_hold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
